// File: rtl/muldiv_sched_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
// Op codes follow the EX decode; states are the sequencer's FSM.
package muldiv_sched_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StMulBusy = 2'b01,
        StDivBusy = 2'b10,
        StDone    = 2'b11
    } md_state_e;

    // Quotient written to LO when the divisor is zero
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    localparam logic Stop    = 1'b1;
    localparam logic NoStop  = 1'b0;
    localparam logic Start   = 1'b1;
    localparam logic NoStart = 1'b0;

    function automatic logic op_is_div(input md_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sched.sv
// Sequences one mult/multu/div/divu at a time through the shared iterative cores,
// stalling EX while a core works and emitting a single-cycle HI/LO write.
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CNT_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic [1:0]  req_op_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic        flush_i,
    output logic        mul_start_o,
    input  logic        mul_ready_i,
    input  logic [63:0] mul_result_i,
    output logic        div_start_o,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic [31:0] core_a_o,
    output logic [31:0] core_b_o,
    output logic        core_signed_o,
    output logic        annul_o,
    output logic        stallreq_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        timeout_o
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic             signed_q, signed_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    md_op_e      req_op;
    logic        is_mul;
    logic        core_ready;
    logic [63:0] core_result;
    logic        cnt_expired;

    assign req_op      = md_op_e'(req_op_i);
    assign is_mul      = (state_q == StMulBusy);
    // Only the core we are waiting on can complete the op
    assign core_ready  = is_mul ? mul_ready_i : div_ready_i;
    assign core_result = is_mul ? mul_result_i : div_result_i;
    assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        signed_d    = signed_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mul_start_o = NoStart;
        div_start_o = NoStart;
        annul_o     = 1'b0;
        stallreq_o  = NoStop;
        hilo_we_o   = 1'b0;
        timeout_o   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid_i && !flush_i) begin
                    stallreq_o = Stop;
                    a_d        = src_a_i;
                    b_d        = src_b_i;
                    signed_d   = op_is_signed(req_op);
                    cnt_d      = '0;
                    if (!op_is_div(req_op)) begin
                        state_d = StMulBusy;
                    end else if (src_b_i == '0) begin
                        // Divide by zero resolves without touching the divider
                        hi_d    = src_a_i;
                        lo_d    = DIV0_LO;
                        state_d = StDone;
                    end else begin
                        state_d = StDivBusy;
                    end
                end
            end

            StMulBusy, StDivBusy: begin
                if (flush_i) begin
                    // Flushed instruction no longer needs EX held
                    annul_o = 1'b1;
                    state_d = StIdle;
                end else begin
                    stallreq_o  = Stop;
                    mul_start_o = is_mul ? Start : NoStart;
                    div_start_o = is_mul ? NoStart : Start;
                    cnt_d       = cnt_q + CNT_W'(1);
                    if (core_ready) begin
                        hi_d    = core_result[63:32];
                        lo_d    = core_result[31:0];
                        state_d = StDone;
                    end else if (cnt_expired) begin
                        mul_start_o = NoStart;
                        div_start_o = NoStart;
                        timeout_o   = 1'b1;
                        annul_o     = 1'b1;
                        state_d     = StIdle;
                    end
                end
            end

            StDone: begin
                hilo_we_o = !flush_i;
                state_d   = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    assign core_a_o      = a_q;
    assign core_b_o      = b_q;
    assign core_signed_o = signed_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule
